// File: rtl/opload_pkg.sv
// Shared types and constants for the operand load sequencer.
package opload_pkg;

   localparam int N_OPS  = 5;
   localparam int SLOT_W = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      START = 2'd2,
      WAIT  = 2'd3
   } opload_state_e;

endpackage

// File: rtl/lsb_pick.sv
// Combinational lowest-set-bit finder for an operand mask.
// Reports the index of the lowest set bit and a flag when no bit is set.
module lsb_pick
   import opload_pkg::*;
#(
   parameter int W = N_OPS
) (
   input  logic [W-1:0]      mask_i,
   output logic [SLOT_W-1:0] idx_o,
   output logic              none_o
);

   // Scan from the top down so the lowest set bit is the last one written
   always_comb begin
      idx_o  = '0;
      none_o = 1'b1;
      for (int i = W - 1; i >= 0; i--) begin
         if (mask_i[i]) begin
            idx_o  = SLOT_W'(i);
            none_o = 1'b0;
         end
      end
   end

endmodule

// File: rtl/operand_load_ctrl.sv
// Operand load sequencer: accepts a command with an operand mask, steers
// each incoming data beat into the next masked slot in ascending order,
// then pulses exec_start and waits for exec_done.
// Optional stall timeout in LOAD is enabled by defining OPLOAD_TIMEOUT_EN.
module operand_load_ctrl #(
   parameter int BUS_WIDTH = 8,
   parameter int N_OPS     = 5,
   parameter int TIMEOUT   = 16
) (
   input  logic                          clk,
   input  logic                          n_reset,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [N_OPS-1:0]              cmd_mask,
   input  logic                          data_valid,
   output logic                          data_ready,
   input  logic [BUS_WIDTH-1:0]          data,
   output logic [N_OPS-1:0]              reg_en,
   output logic [N_OPS*BUS_WIDTH-1:0]    ops,
   output logic                          exec_start,
   input  logic                          exec_done,
   output logic                          busy,
   output logic [opload_pkg::SLOT_W-1:0] slot_idx,
   output logic                          timeout
);
   import opload_pkg::*;

   opload_state_e     state_q, state_d;
   logic [N_OPS-1:0]  pending_q, pending_d;
   logic [SLOT_W-1:0] slot_q, slot_d;

   logic [N_OPS-1:0]  pendingCleared;
   logic [SLOT_W-1:0] cmdIdx, nextIdx;
   logic              cmdNone, nextNone;

   logic cmdReadyC, dataReadyC, execStartC, timeoutC;
   logic [N_OPS-1:0] regEnC;

   assign pendingCleared = pending_q & ~(N_OPS'(1) << slot_q);

   lsb_pick #(.W(N_OPS)) u_cmd_pick (
      .mask_i (cmd_mask),
      .idx_o  (cmdIdx),
      .none_o (cmdNone)
   );

   lsb_pick #(.W(N_OPS)) u_next_pick (
      .mask_i (pendingCleared),
      .idx_o  (nextIdx),
      .none_o (nextNone)
   );

   assign ops = {N_OPS{data}};

`ifdef OPLOAD_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] stall_q, stall_d;

   // Count consecutive stalled LOAD cycles; any transfer, non-LOAD state or abort clears it
   always_comb begin
      stall_d = '0;
      if (state_q == LOAD && !data_valid && !timeoutC) begin
         stall_d = stall_q + CNT_W'(1);
      end
   end

   // Stall counter register
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end
`else
   logic unusedTimeout;
   assign unusedTimeout = ^TIMEOUT;
`endif

   // Next-state and raw handshake outputs of the load sequencer
   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q;
      slot_d      = slot_q;
      cmdReadyC   = 1'b0;
      dataReadyC  = 1'b0;
      execStartC  = 1'b0;
      timeoutC    = 1'b0;
      regEnC      = '0;
      case (state_q)
         IDLE: begin
            cmdReadyC = 1'b1;
            if (cmd_valid) begin
               pending_d = cmd_mask;
               if (cmdNone) begin
                  slot_d  = '0;
                  state_d = START;
               end else begin
                  slot_d  = cmdIdx;
                  state_d = LOAD;
               end
            end
         end
         LOAD: begin
            dataReadyC = 1'b1;
            if (data_valid) begin
               regEnC    = N_OPS'(1) << slot_q;
               pending_d = pendingCleared;
               if (nextNone) begin
                  slot_d  = '0;
                  state_d = START;
               end else begin
                  slot_d  = nextIdx;
               end
            end
`ifdef OPLOAD_TIMEOUT_EN
            else if (stall_q == CNT_W'(TIMEOUT - 1)) begin
               timeoutC  = 1'b1;
               pending_d = '0;
               slot_d    = '0;
               state_d   = IDLE;
            end
`endif
         end
         START: begin
            execStartC = 1'b1;
            state_d    = WAIT;
         end
         WAIT: begin
            if (exec_done) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs are held low for as long as reset is asserted
   always_comb begin
      cmd_ready  = cmdReadyC;
      data_ready = dataReadyC;
      reg_en     = regEnC;
      exec_start = execStartC;
      timeout    = timeoutC;
      busy       = (state_q != IDLE);
      slot_idx   = (state_q == LOAD) ? slot_q : '0;
      if (!n_reset) begin
         cmd_ready  = 1'b0;
         data_ready = 1'b0;
         reg_en     = '0;
         exec_start = 1'b0;
         timeout    = 1'b0;
         busy       = 1'b0;
      end
   end

   // State, pending mask and current slot registers
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state_q   <= IDLE;
         pending_q <= '0;
         slot_q    <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         slot_q    <= slot_d;
      end
   end

endmodule

// File: doc/operand_load_ctrl.md
# operand_load_ctrl

Sequencer that fills the five operand registers of the v3 datapath from a single shared byte stream and then launches execution. It accepts a command carrying a 5-bit operand mask and steers each incoming data beat into the next required operand slot with a one-hot register enable. When every masked slot is loaded it pulses `exec_start`, then waits for `exec_done` before accepting the next command. It sits between the instruction-fetch/decode front end and the operand register bank.

## Interface
- `BUS_WIDTH`, 8: operand width in bits.
- `N_OPS`, 5: number of operand slots; fixed at 5 for v3.
- `TIMEOUT`, 16: stall limit in cycles; used only when `OPLOAD_TIMEOUT_EN` is defined.

- `clk`  in  1  clock; all logic on the rising edge.
- `n_reset`  in  1  reset; synchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_mask`  in  N_OPS  bit i set means slot i must be loaded.
- `data_valid`  in  1  operand beat present.
- `data_ready`  out  1  controller accepts a beat.
- `data`  in  BUS_WIDTH  operand beat.
- `reg_en`  out  N_OPS  one-hot write enable to the operand registers.
- `ops`  out  N_OPS×BUS_WIDTH  `data` broadcast to every slot.
- `exec_start`  out  1  one-cycle launch pulse.
- `exec_done`  in  1  execution finished.
- `busy`  out  1  high in any state other than IDLE.
- `slot_idx`  out  3  slot currently being loaded; 0 outside LOAD.
- `timeout`  out  1  one-cycle abort pulse.

## Operation
- **States:** IDLE, LOAD, START, WAIT.
- **IDLE:** `cmd_ready`=1. On `cmd_valid`:
  - latch `cmd_mask` into `pending`;
  - if the mask is 0, go to START; otherwise set `slot_idx` to the lowest set bit and go to LOAD.
- **LOAD:** `data_ready`=1. On `data_valid`:
  - `reg_en[slot_idx]`=1 combinationally in that same cycle;
  - clear that bit in `pending`;
  - if `pending` is now 0, go to START; otherwise `slot_idx` moves to the next-lowest set bit.
  - Slots are loaded in strictly ascending index order. Unmasked slots never see `reg_en`.
- **START:** `exec_start`=1 for exactly one cycle, then go to WAIT.
- **WAIT:** on `exec_done`, go to IDLE.
- `exec_done` is ignored in every state other than WAIT. `cmd_valid` and `data_valid` are ignored outside IDLE and LOAD respectively.
- `reg_en` is 0 whenever no transfer occurs. It is never more than one-hot.
- **Reset:** while `n_reset` is low, `cmd_ready`, `data_ready`, `reg_en`, `exec_start`, `busy` and `timeout` are forced to 0. After the first rising edge with `n_reset` low:
  - state is IDLE;
  - `pending` and `slot_idx` are 0;
  - the stall counter is 0.
- **Reset mid-operation:** reset in any state aborts to IDLE with no `exec_start`. Operand registers already written keep their values; clearing them is the register bank's own reset.

## Timing
- Command accept edge → `data_ready`=1 in the next cycle.
- Zero mask: accept → `exec_start` in the next cycle.
- Last data beat edge → `exec_start` in the next cycle.
- The first operand beat is accepted no earlier than one cycle after the command is accepted. Back-to-back beats then load one slot per cycle.
- `exec_done` edge → `cmd_ready`=1 in the next cycle.
- Minimum command period: 2 + popcount(mask) + exec latency cycles.

## Configuration
- **`OPLOAD_TIMEOUT_EN` defined:**
  - a stall counter of $clog2(TIMEOUT+1) bits counts consecutive LOAD cycles without a transfer and resets to 0 on every transfer and on LOAD entry;
  - when it reaches `TIMEOUT`, `timeout` pulses for one cycle and the state goes to IDLE, with no `exec_start` and `pending` cleared;
  - a transfer in the same cycle as the limit wins, and no timeout fires.
- **`OPLOAD_TIMEOUT_EN` undefined:** no counter exists, `timeout` is tied to 0, and LOAD waits indefinitely.

## Structure
- **`opload_pkg`:**
  - `opload_state_e` enum (IDLE, LOAD, START, WAIT);
  - `N_OPS` constant (5);
  - `SLOT_W` constant (3).
- **Sub-module `lsb_pick`:** combinational lowest-set-bit finder for the N_OPS mask. It outputs the index and a `none` flag, and is used both for command accept and for each slot advance.

## Test plan
- **Full mask, back-to-back beats:** `cmd_mask`=5'b11111, beats 0x10..0x14 → `reg_en` steps 00001→10000 on consecutive cycles, `exec_start` one cycle after beat 0x14.
- **Sparse mask with stalls:** `cmd_mask`=5'b10010, beats 0xAA, 0xBB with 3-cycle `data_valid` gaps → `reg_en` is 00010 then 10000, `slot_idx` is 1 then 4, and slots 0/2/3 are never enabled.
- **Zero mask:** `cmd_mask`=0 → `exec_start` the cycle after accept, `data_ready` never asserts. Then `exec_done` → `cmd_ready`=1 the next cycle.
- **Stray `exec_done`:** `exec_done` held high during LOAD and START → ignored; the state only leaves WAIT on a post-START `exec_done`.
- **Reset mid-LOAD:** reset after 2 of 4 beats → all outputs 0 during reset, IDLE with `cmd_ready`=1 afterwards, no `exec_start`.
- **Timeout (with `OPLOAD_TIMEOUT_EN`, `TIMEOUT`=4):** mask 5'b00001 with no data → `timeout` pulses 4 cycles after LOAD entry and the state returns to IDLE. A beat arriving in the 4th stalled cycle → loads normally with no timeout.
